// File: rtl/pixel_scheduler.sv
// pixel_scheduler: raster-order Mandelbrot pixel dispatcher for a bank of
// escape-time cores, with strictly in-order depth collection.
//
// Ports:
//   sysclk, reset_n            clock, synchronous active-low reset
//   frame_start, cfg_*         frame trigger and per-frame configuration
//   core_reset, core_start     core bank control (reset shared, start per core)
//   core_x/y/re_c/im_c         per-core pixel inputs, held while iterating
//   core_max_iter              latched iteration limit, shared by all cores
//   core_done, core_depth      per-core completion pulse and result
//   pix_valid/ready, pix_*     raster-ordered output pixel stream
//   busy, frame_done           frame status
module pixel_scheduler #(
    parameter int NUM_CORES   = 4,
    parameter int WORD_LENGTH = 32,
    parameter int FRAC        = 28
) (
    input  logic                               sysclk,
    input  logic                               reset_n,
    input  logic                               frame_start,
    input  logic [10:0]                        cfg_width,
    input  logic [10:0]                        cfg_height,
    input  logic signed [WORD_LENGTH-1:0]      cfg_re_start,
    input  logic signed [WORD_LENGTH-1:0]      cfg_im_start,
    input  logic signed [WORD_LENGTH-1:0]      cfg_step,
    input  logic [10:0]                        cfg_max_iter,
    output logic                               core_reset,
    output logic [NUM_CORES-1:0]               core_start,
    output logic [NUM_CORES*11-1:0]            core_x,
    output logic [NUM_CORES*11-1:0]            core_y,
    output logic [NUM_CORES*WORD_LENGTH-1:0]   core_re_c,
    output logic [NUM_CORES*WORD_LENGTH-1:0]   core_im_c,
    output logic [10:0]                        core_max_iter,
    input  logic [NUM_CORES-1:0]               core_done,
    input  logic [NUM_CORES*11-1:0]            core_depth,
    output logic                               pix_valid,
    input  logic                               pix_ready,
    output logic [10:0]                        pix_x,
    output logic [10:0]                        pix_y,
    output logic [10:0]                        pix_depth,
    output logic                               pix_sof,
    output logic                               pix_last,
    output logic                               busy,
    output logic                               frame_done
);

    localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    // FRAC only describes the c format for the cores; nothing here uses it.
    localparam int unused_frac = FRAC;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state;

    // Latched frame configuration
    logic [10:0]                   width;
    logic [10:0]                   height;
    logic signed [WORD_LENGTH-1:0] re0;
    logic signed [WORD_LENGTH-1:0] step;
    logic [10:0]                   max_iter;

    // Raster scan counters; c is generated incrementally
    logic [10:0]                   sx;
    logic [10:0]                   sy;
    logic signed [WORD_LENGTH-1:0] sre;
    logic signed [WORD_LENGTH-1:0] sim;

    logic [PW-1:0]                 d_ptr;
    logic [PW-1:0]                 c_ptr;
    logic [NUM_CORES-1:0]          cbusy;
    logic [NUM_CORES-1:0]          rvalid;

    logic [10:0]                   cx   [NUM_CORES];
    logic [10:0]                   cy   [NUM_CORES];
    logic [WORD_LENGTH-1:0]        cre  [NUM_CORES];
    logic [WORD_LENGTH-1:0]        cim  [NUM_CORES];
    logic [10:0]                   cdep [NUM_CORES];

    logic [NUM_CORES-1:0]          start_q;
    logic                          core_rst_q;
    logic                          busy_q;
    logic                          fdone_q;

    logic x_end;
    logic y_end;
    logic last_pix;
    logic zero_size;
    logic can_disp;
    logic accept;
    logic out_last;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        if (p == PW'(NUM_CORES - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign x_end     = (sx == 11'(width - 11'd1));
    assign y_end     = (sy == 11'(height - 11'd1));
    assign last_pix  = x_end && y_end;
    assign zero_size = (width == 11'd0) || (height == 11'd0);

    // Dispatch looks only at registered flags, so a core whose result is
    // accepted this cycle is reused one cycle later.
    assign can_disp = ((state == INIT) || (state == RUN)) && !zero_size
                   && !cbusy[d_ptr] && !rvalid[d_ptr];

    assign pix_valid = rvalid[c_ptr];
    assign pix_x     = cx[c_ptr];
    assign pix_y     = cy[c_ptr];
    assign pix_depth = cdep[c_ptr];
    assign out_last  = (cx[c_ptr] == 11'(width - 11'd1))
                    && (cy[c_ptr] == 11'(height - 11'd1));
    assign pix_sof   = pix_valid && (cx[c_ptr] == 11'd0) && (cy[c_ptr] == 11'd0);
    assign pix_last  = pix_valid && out_last;
    assign accept    = pix_valid && pix_ready;

    assign core_reset    = core_rst_q || !reset_n;
    assign core_start    = start_q;
    assign core_max_iter = max_iter;
    assign busy          = busy_q;
    assign frame_done    = fdone_q;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_out
        assign core_x[g*11 +: 11]                   = cx[g];
        assign core_y[g*11 +: 11]                   = cy[g];
        assign core_re_c[g*WORD_LENGTH +: WORD_LENGTH] = cre[g];
        assign core_im_c[g*WORD_LENGTH +: WORD_LENGTH] = cim[g];
    end

    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            state      <= IDLE;
            width      <= '0;
            height     <= '0;
            re0        <= '0;
            step       <= '0;
            max_iter   <= '0;
            sx         <= '0;
            sy         <= '0;
            sre        <= '0;
            sim        <= '0;
            d_ptr      <= '0;
            c_ptr      <= '0;
            cbusy      <= '0;
            rvalid     <= '0;
            start_q    <= '0;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            fdone_q    <= 1'b0;
            for (int k = 0; k < NUM_CORES; k++) begin
                cx[k]   <= '0;
                cy[k]   <= '0;
                cre[k]  <= '0;
                cim[k]  <= '0;
                cdep[k] <= '0;
            end
        end else begin
            start_q    <= '0;
            core_rst_q <= 1'b0;
            fdone_q    <= 1'b0;

            if (frame_start) begin
                // Abort anything in flight and restart from pixel (0,0).
                width      <= cfg_width;
                height     <= cfg_height;
                re0        <= cfg_re_start;
                step       <= cfg_step;
                max_iter   <= cfg_max_iter;
                sx         <= '0;
                sy         <= '0;
                sre        <= cfg_re_start;
                sim        <= cfg_im_start;
                d_ptr      <= '0;
                c_ptr      <= '0;
                cbusy      <= '0;
                rvalid     <= '0;
                core_rst_q <= 1'b1;
                busy_q     <= 1'b1;
                state      <= INIT;
            end else begin
                // done only sets rvalid on busy cores and accept only
                // clears it on non-busy ones, so the writes never collide.
                for (int k = 0; k < NUM_CORES; k++) begin
                    if (core_done[k] && cbusy[k]) begin
                        cdep[k]   <= core_depth[k*11 +: 11];
                        cbusy[k]  <= 1'b0;
                        rvalid[k] <= 1'b1;
                    end
                end

                if (accept) begin
                    rvalid[c_ptr] <= 1'b0;
                    c_ptr         <= nxt(c_ptr);
                end

                if (can_disp) begin
                    cx[d_ptr]      <= sx;
                    cy[d_ptr]      <= sy;
                    cre[d_ptr]     <= sre;
                    cim[d_ptr]     <= sim;
                    cbusy[d_ptr]   <= 1'b1;
                    start_q[d_ptr] <= 1'b1;
                    d_ptr          <= nxt(d_ptr);
                    if (x_end) begin
                        sx  <= '0;
                        sre <= re0;
                        sy  <= sy + 11'd1;
                        sim <= sim - step;
                    end else begin
                        sx  <= sx + 11'd1;
                        sre <= sre + step;
                    end
                end

                unique case (state)
                    IDLE: begin
                    end
                    INIT: begin
                        if (zero_size) begin
                            state   <= DONE;
                            busy_q  <= 1'b0;
                            fdone_q <= 1'b1;
                        end else if (can_disp && last_pix) begin
                            state <= DRAIN;
                        end else begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (can_disp && last_pix) begin
                            state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (accept && out_last) begin
                            state   <= DONE;
                            busy_q  <= 1'b0;
                            fdone_q <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pixel_scheduler.sv
// tb_pixel_scheduler: scoreboard bench for pixel_scheduler with
// behavioural fixed-latency cores.
module tb_pixel_scheduler;

    localparam int NC = 4;
    localparam int WL = 32;

    logic              sysclk = 1'b0;
    logic              reset_n;
    logic              frame_start;
    logic [10:0]       cfg_width;
    logic [10:0]       cfg_height;
    logic [WL-1:0]     cfg_re_start;
    logic [WL-1:0]     cfg_im_start;
    logic [WL-1:0]     cfg_step;
    logic [10:0]       cfg_max_iter;
    logic              core_reset;
    logic [NC-1:0]     core_start;
    logic [NC*11-1:0]  core_x;
    logic [NC*11-1:0]  core_y;
    logic [NC*WL-1:0]  core_re_c;
    logic [NC*WL-1:0]  core_im_c;
    logic [10:0]       core_max_iter;
    logic [NC-1:0]     core_done;
    logic [NC*11-1:0]  core_depth;
    logic              pix_valid;
    logic              pix_ready;
    logic [10:0]       pix_x;
    logic [10:0]       pix_y;
    logic [10:0]       pix_depth;
    logic              pix_sof;
    logic              pix_last;
    logic              busy;
    logic              frame_done;

    always #5 sysclk = ~sysclk;

    pixel_scheduler #(.NUM_CORES(NC), .WORD_LENGTH(WL), .FRAC(28)) dut (
        .sysclk(sysclk), .reset_n(reset_n), .frame_start(frame_start),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_re_start(cfg_re_start), .cfg_im_start(cfg_im_start),
        .cfg_step(cfg_step), .cfg_max_iter(cfg_max_iter),
        .core_reset(core_reset), .core_start(core_start),
        .core_x(core_x), .core_y(core_y),
        .core_re_c(core_re_c), .core_im_c(core_im_c),
        .core_max_iter(core_max_iter), .core_done(core_done),
        .core_depth(core_depth), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
        .pix_depth(pix_depth), .pix_sof(pix_sof), .pix_last(pix_last),
        .busy(busy), .frame_done(frame_done)
    );

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [10:0] d;
        logic        sof;
        logic        last;
    } pix_t;

    typedef struct packed {
        logic [10:0]   x;
        logic [10:0]   y;
        logic [WL-1:0] re;
        logic [WL-1:0] im;
    } c_t;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int fid      = 0;
    int emit_cnt = 0;
    int done_cnt = 0;
    int last_cyc = 0;
    int lat [NC];

    pix_t pq [$];
    c_t   cq [$];
    logic [NC-1:0] outst;
    logic stall_prev;
    pix_t stall_val;
    pix_t cur;
    pix_t pe;
    c_t   ce;
    logic hold_low;
    logic rnd_ready;

    int       cnt [NC];
    logic [10:0] dep [NC];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] depth_of(input logic [10:0] x,
                                             input logic [10:0] y,
                                             input int f);
        int v;
        v = int'(x) * 3 + int'(y) * 17 + f * 101;
        return v[10:0];
    endfunction

    always @(posedge sysclk) cyc <= cyc + 1;

    // Behavioural cores: done exactly lat[k] cycles after start.
    always @(posedge sysclk) begin
        #1;
        core_done = '0;
        for (int k = 0; k < NC; k++) begin
            if (core_reset) begin
                cnt[k] = 0;
            end else if (core_start[k]) begin
                cnt[k] = lat[k];
                dep[k] = depth_of(core_x[k*11 +: 11], core_y[k*11 +: 11], fid);
            end else if (cnt[k] != 0) begin
                cnt[k] = cnt[k] - 1;
                if (cnt[k] == 0) begin
                    core_done[k] = 1'b1;
                    core_depth[k*11 +: 11] = dep[k];
                end
            end
        end
    end

    always @(posedge sysclk) begin
        #1;
        if (hold_low) pix_ready = 1'b0;
        else if (rnd_ready) pix_ready = 1'($urandom_range(0, 1));
        else pix_ready = 1'b1;
    end

    // Monitor: dispatch order, output order, stall stability.
    always @(negedge sysclk) begin
        cur = {pix_x, pix_y, pix_depth, pix_sof, pix_last};
        if (reset_n && !frame_start) begin
            if (stall_prev) begin
                check("stall_valid", 64'(pix_valid), 64'(1));
                check("stall_hold", 64'(cur), 64'(stall_val));
            end
            stall_prev = pix_valid && !pix_ready;
            stall_val  = cur;
            for (int k = 0; k < NC; k++) begin
                if (core_start[k]) begin
                    check("redispatch", 64'(outst[k]), 64'(0));
                    outst[k] = 1'b1;
                    check("c_pending", 64'(cq.size() != 0), 64'(1));
                    if (cq.size() != 0) begin
                        ce = cq.pop_front();
                        check("c_xy", 64'({core_x[k*11 +: 11], core_y[k*11 +: 11]}),
                              64'({ce.x, ce.y}));
                        check("c_re", 64'(core_re_c[k*WL +: WL]), 64'(ce.re));
                        check("c_im", 64'(core_im_c[k*WL +: WL]), 64'(ce.im));
                    end
                end
            end
            if (pix_valid && pix_ready) begin
                check("pix_pending", 64'(pq.size() != 0), 64'(1));
                if (pq.size() != 0) begin
                    pe = pq.pop_front();
                    check("pix", 64'(cur), 64'(pe));
                end
                outst[emit_cnt % NC] = 1'b0;
                emit_cnt++;
                if (pix_last) last_cyc = cyc;
            end
            if (frame_done) done_cnt++;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic start_frame(input int w, input int h, input logic [WL-1:0] re,
                               input logic [WL-1:0] im, input logic [WL-1:0] st,
                               input int mi);
        logic zero;
        zero = (w == 0) || (h == 0);
        @(posedge sysclk);
        #1;
        cfg_width    = 11'(w);
        cfg_height   = 11'(h);
        cfg_re_start = re;
        cfg_im_start = im;
        cfg_step     = st;
        cfg_max_iter = 11'(mi);
        frame_start  = 1'b1;
        fid++;
        pq.delete();
        cq.delete();
        outst    = '0;
        emit_cnt = 0;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                pq.push_back('{x: 11'(x), y: 11'(y),
                               d: depth_of(11'(x), 11'(y), fid),
                               sof: (x == 0 && y == 0),
                               last: (x == w - 1 && y == h - 1)});
                cq.push_back('{x: 11'(x), y: 11'(y),
                               re: re + st * WL'(x),
                               im: im - st * WL'(y)});
            end
        end
        @(posedge sysclk);
        #1;
        frame_start  = 1'b0;
        cfg_width    = 11'($urandom);
        cfg_height   = 11'($urandom);
        cfg_re_start = $urandom;
        cfg_step     = $urandom;
        cfg_max_iter = 11'($urandom);
        @(negedge sysclk);
        check("fs_core_reset", 64'(core_reset), 64'(1));
        check("fs_busy", 64'(busy), 64'(1));
        check("fs_max_iter", 64'(core_max_iter), 64'(mi));
        @(negedge sysclk);
        if (zero) begin
            check("zero_start", 64'(core_start), 64'(0));
            check("zero_done", 64'(frame_done), 64'(1));
        end else begin
            check("first_start", 64'(core_start), 64'(1));
        end
    endtask

    task automatic wait_done();
        int n;
        int d0;
        n  = 0;
        d0 = done_cnt;
        while (n < 4000 && !frame_done) begin
            @(negedge sysclk);
            n++;
        end
        check("done_seen", 64'(frame_done), 64'(1));
        check("done_lat", 64'(cyc - last_cyc), 64'(1));
        check("done_busy", 64'(busy), 64'(0));
        check("pix_left", 64'(pq.size()), 64'(0));
        check("c_left", 64'(cq.size()), 64'(0));
        repeat (3) @(negedge sysclk);
        check("done_once", 64'(done_cnt - d0), 64'(1));
    endtask

    task automatic wait_emit(input int target);
        int n;
        n = 0;
        while (n < 2000 && emit_cnt < target) begin
            @(negedge sysclk);
            n++;
        end
        check("emit_wait", 64'(emit_cnt >= target), 64'(1));
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_core_reset"}, 64'(core_reset), 64'(1));
        check({tag, "_ctrl"}, 64'({core_start, pix_valid, busy, frame_done}), 64'(0));
        check({tag, "_pix"}, 64'({pix_x, pix_y, pix_depth, pix_sof, pix_last}), 64'(0));
        check({tag, "_cxy"}, 64'({core_x, core_y, core_max_iter}), 64'(0));
        check({tag, "_cc"}, 64'(|{core_re_c, core_im_c}), 64'(0));
    endtask

    initial begin
        reset_n      = 1'b0;
        frame_start  = 1'b0;
        cfg_width    = '0;
        cfg_height   = '0;
        cfg_re_start = '0;
        cfg_im_start = '0;
        cfg_step     = '0;
        cfg_max_iter = '0;
        core_done    = '0;
        core_depth   = '0;
        pix_ready    = 1'b1;
        hold_low     = 1'b0;
        rnd_ready    = 1'b0;
        outst        = '0;
        stall_prev   = 1'b0;
        lat          = '{5, 5, 5, 5};
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        check_reset_outs("rst0");
        @(posedge sysclk);
        #1;
        reset_n = 1'b1;

        // 4x2 frame, fixed latency, always ready
        start_frame(4, 2, 32'h0000_1000, 32'h0000_2000, 32'h0000_0010, 100);
        wait_done();

        // slow core 0 forces the others to hold results
        lat = '{20, 3, 3, 3};
        start_frame(4, 1, 32'h0100_0000, 32'h0, 32'h0000_0100, 50);
        wait_done();

        // Q4.28 c sequence
        lat = '{5, 5, 5, 5};
        start_frame(3, 2, 32'hE000_0000, 32'h1000_0000, 32'h0800_0000, 255);
        wait_done();

        // backpressure held low for 50 cycles mid-frame
        for (int k = 0; k < NC; k++) lat[k] = int'($urandom_range(1, 12));
        start_frame(8, 4, 32'hF000_0000, 32'h0800_0000, 32'h0040_0000, 300);
        wait_emit(5);
        hold_low = 1'b1;
        repeat (50) @(posedge sysclk);
        hold_low = 1'b0;
        wait_done();

        // random backpressure, wrapping c arithmetic
        rnd_ready = 1'b1;
        start_frame(5, 3, 32'h7FFF_FFF0, 32'h8000_0004, 32'h0000_0008, 7);
        wait_done();
        rnd_ready = 1'b0;

        // restart mid-frame
        lat = '{7, 7, 7, 7};
        start_frame(4, 4, 32'h0, 32'h0, 32'h0000_1000, 20);
        wait_emit(3);
        lat = '{4, 6, 2, 9};
        start_frame(3, 2, 32'h0200_0000, 32'h0300_0000, 32'h0000_2000, 21);
        wait_done();

        // empty frames
        start_frame(0, 2, 32'h0, 32'h0, 32'h1, 9);
        start_frame(4, 0, 32'h0, 32'h0, 32'h1, 9);
        repeat (5) @(negedge sysclk);
        check("zero_idle_busy", 64'(busy), 64'(0));

        // one-cycle reset mid-frame
        lat = '{5, 5, 5, 5};
        start_frame(8, 2, 32'h0, 32'h0, 32'h0000_0100, 33);
        repeat (10) @(posedge sysclk);
        #1;
        reset_n = 1'b0;
        pq.delete();
        cq.delete();
        outst    = '0;
        emit_cnt = 0;
        @(posedge sysclk);
        #1;
        reset_n = 1'b1;
        @(negedge sysclk);
        check_reset_outs("rst1");
        @(negedge sysclk);
        check("rst1_release", 64'({core_reset, core_start, pix_valid, busy}), 64'(0));

        start_frame(2, 2, 32'h1234_0000, 32'h0000_5678, 32'h0001_0000, 44);
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_scheduler.md
# pixel_scheduler

Frame-level controller that shares a bank of `NUM_CORES` escape-time iteration cores across one Mandelbrot frame. It scans pixels in raster order and generates each pixel's complex constant incrementally (no multiplier). It dispatches pixels round-robin to idle cores, holds each core's inputs stable while it iterates, and returns depths to the pixel-stream side strictly in raster order. It sits between the register/config block and the video pixel FIFO.

## Interface
- `NUM_CORES`, 4, number of iteration cores (2–8).
- `WORD_LENGTH`, 32, fixed-point word width of c values.
- `FRAC`, 28, fractional bits; passed through only, no arithmetic depends on it.
- `sysclk` in 1, system clock.
- `reset_n` in 1, synchronous active-low reset.
- `frame_start` in 1, pulse; latches config and starts a frame (aborts any frame in progress).
- `cfg_width`, `cfg_height` in 11 each, frame size in pixels.
- `cfg_re_start`, `cfg_im_start` in WORD_LENGTH signed, c of pixel (0,0).
- `cfg_step` in WORD_LENGTH signed, c delta per pixel.
- `cfg_max_iter` in 11, broadcast to cores.
- `core_reset` out 1, active-high reset to all cores.
- `core_start` out NUM_CORES, one-cycle start pulse per core.
- `core_x`, `core_y` out NUM_CORES×11, per-core pixel coordinates.
- `core_re_c`, `core_im_c` out NUM_CORES×WORD_LENGTH, per-core c.
- `core_max_iter` out 11, latched `cfg_max_iter`.
- `core_done` in NUM_CORES, one-cycle done pulse per core.
- `core_depth` in NUM_CORES×11, per-core final depth, valid with done.
- `pix_valid`, `pix_ready` out/in 1, output stream handshake.
- `pix_x`, `pix_y`, `pix_depth` out 11 each, output pixel.
- `pix_sof`, `pix_last` out 1, first / last pixel of frame, qualified by `pix_valid`.
- `busy` out 1, high from accepted `frame_start` until `frame_done`.
- `frame_done` out 1, one-cycle pulse after the last pixel is accepted.

## Operation
- Top FSM: IDLE → RUN on `frame_start`; RUN → DRAIN when all pixels are dispatched; DRAIN → DONE when the last pixel is accepted; DONE → IDLE after one cycle (`frame_done` = 1).
- Config is latched on `frame_start` and ignored afterwards.
- Zero `cfg_width` or `cfg_height` goes IDLE → DONE directly, with no pixels emitted.
- Each core has a `busy` flag, a `rvalid` flag, a depth register and c/x/y registers.
- Dispatch pointer `d_ptr` and collect pointer `c_ptr` each wrap modulo NUM_CORES.
- Dispatch in RUN:
  - Condition: `!busy[d_ptr] && !rvalid[d_ptr]`.
  - Action: load that core's x/y/c from the scan counters, pulse `core_start[d_ptr]`, set `busy`, advance the scan, advance `d_ptr`.
  - At most one dispatch per cycle.
- Scan counters:
  - Along a row: x += 1, re += step.
  - At x = width−1: x ← 0, re ← re_start, y += 1, im −= step.
  - Arithmetic is two's-complement wrap.
- `core_done[k]` while `busy[k]`: capture depth, clear `busy[k]`, set `rvalid[k]`. `core_done` on a non-busy core is ignored.
- Output:
  - `pix_valid = rvalid[c_ptr]`, with x/y/depth taken from core `c_ptr`.
  - On `pix_valid && pix_ready`: clear `rvalid[c_ptr]`, advance `c_ptr`.
  - Outputs hold stable while `pix_valid && !pix_ready`.
- `pix_sof` is high for pixel (0,0); `pix_last` is high for pixel (width−1, height−1).
- Simultaneous output accept and dispatch on the same core index: the dispatch waits one cycle, because the dispatch condition uses the registered `rvalid`.
- `frame_start` mid-frame:
  - `core_reset` pulses high for one cycle.
  - All busy/rvalid flags and pointers clear; pending results are discarded.
  - The new frame's first dispatch is no earlier than 2 cycles after `frame_start`.
- Reset values:
  - `core_reset` = 1 while `reset_n` = 0.
  - All other outputs 0.
  - FSM in IDLE.

## Timing
- `frame_start` at cycle t gives the first `core_start` at t+2 (t+1 is used by `core_reset` / config latch).
- Core registers update in the same cycle `core_start` is high, and hold until the next dispatch to that core.
- `core_done` at cycle t makes `pix_valid` high at t+1, if that core is at `c_ptr`.
- A freed core can be redispatched 1 cycle after its pixel is accepted.
- `frame_done` is asserted 1 cycle after the `pix_last` handshake; `busy` falls in the same cycle.

## Test plan
1. **4×2 frame, 4 cores, behavioural cores with fixed 5-cycle latency, `pix_ready` = 1** → 8 pixels in order (0,0)…(3,1), `pix_sof` on the first, `pix_last` on the eighth, one `frame_done`.
2. **Core latencies 20/3/3/3 on a 4×1 frame** → output still x = 0,1,2,3; cores 1–3 hold results until core 0 finishes.
3. **re_start = −2.0, im_start = 1.0, step = 0.5 (Q4.28), 3×2 frame** → core re_c sequence −2.0, −1.5, −1.0, −2.0, −1.5, −1.0; im_c = 1.0 ×3, then 0.5 ×3.
4. **`pix_ready` held 0 for 50 cycles mid-frame** → no core is redispatched while its `rvalid` is set; outputs stay stable; no pixel is lost or duplicated.
5. **`frame_start` reasserted mid-frame** → `core_reset` pulses for one cycle; the next emitted pixel is (0,0) with `pix_sof`; no stale depth appears.
6. **`cfg_width` = 0** → no `core_start`; `frame_done` pulses 2 cycles after `frame_start`. **`reset_n` = 0 for one cycle** → all outputs return to their reset values.
